// File: rtl/gray_stream_arbiter_pkg.sv
// Shared types and widths for the two-source grayscale stream arbiter.
package gray_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2
    } arb_state_e;

    localparam int RGB_W   = 24;
    localparam int GRAY_W  = 8;
    localparam int NUM_SRC = 2;

    function automatic arb_state_e serve_state(input logic sid);
        return sid ? ST_SERVE1 : ST_SERVE0;
    endfunction

endpackage

// File: rtl/gray_stream_arbiter_rr_burst_fsm.sv
// Burst round-robin grant FSM for two sources: BURST reads per grant, work-conserving,
// holds the grant under output back-pressure.
module rr_burst_fsm
    import gray_stream_arbiter_pkg::*;
#(
    parameter int BURST = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       rd,
    input  logic       bp,
    output logic       gnt_vld,
    output logic       gnt_sid
);

    localparam int CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          cur, oth;

    assign cur = (state_q == ST_SERVE1);
    assign oth = ~cur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req[~last_q])
                    state_d = serve_state(~last_q);
                else if (req[last_q])
                    state_d = serve_state(last_q);
            end
            ST_SERVE0, ST_SERVE1: begin
                // back-pressure with work pending freezes both grant and count
                if (!(bp && req[cur])) begin
                    if (rd && cnt_q == LAST) begin
                        cnt_d = '0;
                        if (req[oth]) begin
                            state_d = serve_state(oth);
                            last_d  = cur;
                        end else if (!req[cur]) begin
                            state_d = ST_IDLE;
                            last_d  = cur;
                        end
                    end else if (rd) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (!req[cur]) begin
                        cnt_d   = '0;
                        last_d  = cur;
                        state_d = req[oth] ? serve_state(oth) : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_vld = (state_q != ST_IDLE);
    assign gnt_sid = (state_q == ST_SERVE1);

endmodule

// File: rtl/gray_stream_arbiter.sv
// Shares one grayscale stage between two pixel streams: muxes the input FIFO read side
// to the stage and demuxes its one-cycle-later results to the matching output FIFO.
module gray_stream_arbiter
    import gray_stream_arbiter_pkg::*;
#(
    parameter int DWIDTH_IN  = RGB_W,
    parameter int DWIDTH_OUT = GRAY_W,
    parameter int BURST      = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in0_rd_en,
    input  logic [DWIDTH_IN-1:0]  in0_dout,
    input  logic                  in0_empty,
    output logic                  in1_rd_en,
    input  logic [DWIDTH_IN-1:0]  in1_dout,
    input  logic                  in1_empty,
    input  logic                  gs_rd_en,
    output logic [DWIDTH_IN-1:0]  gs_dout,
    output logic                  gs_empty,
    input  logic                  gs_wr_en,
    input  logic [DWIDTH_OUT-1:0] gs_din,
    output logic                  gs_full,
    output logic                  out0_wr_en,
    output logic [DWIDTH_OUT-1:0] out0_din,
    input  logic                  out0_full,
    output logic                  out1_wr_en,
    output logic [DWIDTH_OUT-1:0] out1_din,
    input  logic                  out1_full,
    output logic                  gnt_sid,
    output logic                  gnt_vld
);

    logic [NUM_SRC-1:0]                in_empty, out_full, in_rd, out_wr;
    logic [NUM_SRC-1:0][DWIDTH_IN-1:0] in_dout;
    logic                              sid_d;

    assign in_empty = {in1_empty, in0_empty};
    assign out_full = {out1_full, out0_full};
    assign in_dout  = {in1_dout, in0_dout};

    rr_burst_fsm #(.BURST(BURST)) u_fsm (
        .clock   (clock),
        .reset   (reset),
        .req     (~in_empty),
        .rd      (gs_rd_en & gnt_vld),
        .bp      (gs_full),
        .gnt_vld (gnt_vld),
        .gnt_sid (gnt_sid)
    );

    always_comb begin
        gs_dout  = '0;
        gs_empty = 1'b1;
        gs_full  = 1'b0;
        if (gnt_vld) begin
            gs_dout  = in_dout[gnt_sid];
            gs_empty = in_empty[gnt_sid];
            gs_full  = out_full[gnt_sid];
        end
    end

    // results follow the source of the pixel read one cycle earlier, not the live grant
    always_ff @(posedge clock) begin
        if (reset)
            sid_d <= 1'b0;
        else if (gs_rd_en)
            sid_d <= gnt_sid;
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign in_rd[s]  = gs_rd_en & gnt_vld & (gnt_sid == 1'(s)) & ~reset;
        assign out_wr[s] = gs_wr_en & (sid_d == 1'(s)) & ~reset;
    end

    assign in0_rd_en  = in_rd[0];
    assign in1_rd_en  = in_rd[1];
    assign out0_wr_en = out_wr[0];
    assign out1_wr_en = out_wr[1];
    assign out0_din   = gs_din;
    assign out1_din   = gs_din;

endmodule
